// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
//
// Byte-wide UART transmitter. Bytes arrive over a valid/ready handshake,
// are buffered in a small FIFO, and are shifted out one bit per baud_tick.
//
// Frame format on tx:
//   start (0), data[0] .. data[7] (LSB first), [even parity], stop (1)
//
// The frame format matches the companion receiver. If a byte is already
// queued when a stop bit ends, the next start bit follows with no idle gap.
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int FIFO_DEPTH = 4,    // power of two, >= 2
  parameter bit PARITY_EN  = 1'b1  // 1: append even-parity bit after data
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // -------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // -------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // -------------------------------------------------------------------------
  // Transmit datapath
  // -------------------------------------------------------------------------
  state_t     state;
  logic [7:0] shift;
  logic       parity;
  logic [2:0] bit_cnt;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign tx_ready   = !full;
  assign fifo_count = count;
  assign head       = mem[rd_ptr];
  assign tx_busy    = (state != IDLE);

  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign push = tx_valid && !full;

  // Bytes leave the FIFO only when a frame begins: on a tick in IDLE, or on
  // the tick that ends a stop bit (back-to-back frames).
  assign pop  = baud_tick && !empty && ((state == IDLE) || (state == STOP));

  // Byte storage: written on every accepted push.
  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because
  // FIFO_DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were just before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer: advances one bit per baud_tick and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      shift   <= '0;
      parity  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      tx_done <= 1'b0;
      if (baud_tick) begin
        case (state)
          IDLE: begin
            if (pop) begin
              shift  <= head;
              parity <= ^head;
              tx     <= 1'b0;
              state  <= START;
            end else begin
              tx <= 1'b1;
            end
          end

          START: begin
            tx      <= shift[0];
            bit_cnt <= '0;
            state   <= DATA;
          end

          DATA: begin
            if (bit_cnt != 3'd7) begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end else if (PARITY_EN) begin
              tx    <= parity;
              state <= PARITY;
            end else begin
              tx    <= 1'b1;
              state <= STOP;
            end
          end

          PARITY: begin
            tx    <= 1'b1;
            state <= STOP;
          end

          STOP: begin
            tx_done <= 1'b1;
            if (pop) begin
              shift  <= head;
              parity <= ^head;
              tx     <= 1'b0;
              state  <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end

          default: begin
            tx    <= 1'b1;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
//
// Two transmitters share one stimulus stream: lane 0 has parity enabled and
// lane 1 has it disabled. Each lane has its own scoreboard. Every accepted
// handshake pushes the byte's expected frame, which is built from the
// frame-format rules. A monitor samples the line after each baud tick. It
// rebuilds frames and checks them in order, and it also checks start
// latency, the tx_done pulse, tx_busy, holding between ticks, and FIFO
// occupancy.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [1:0] tx_ready;
  logic [1:0] tx_line;
  logic [1:0] tx_busy;
  logic [1:0] tx_done;
  logic [2:0] fifo_count [2];

  int n_tests   = 0;
  int n_fail    = 0;
  int tick_mode = 0;   // 0 off, 1 every 16 clks, 2 every clk, 3 random

  always #5 clk = ~clk;

  function automatic void check(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Expected line levels for one frame, index 0 first on the wire.
  // Bits beyond the frame length stay 1.
  function automatic logic [10:0] frame_bits(logic [7:0] d, bit pe);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (pe) f[9] = ^d;
    return f;
  endfunction

  // -------------------------------------------------------------------------
  // DUT lanes with per-lane scoreboard and monitor
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam bit PE = (g == 0);
    localparam int NB = PE ? 11 : 10;

    uart_tx #(.FIFO_DEPTH(DEPTH), .PARITY_EN(PE)) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_tick  (baud_tick),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready[g]),
      .tx         (tx_line[g]),
      .tx_busy    (tx_busy[g]),
      .tx_done    (tx_done[g]),
      .fifo_count (fifo_count[g])
    );

    logic [10:0] exp_q [$];
    logic [10:0] cur_exp;
    logic [10:0] got;
    int          pos         = 0;
    bit          in_frame    = 1'b0;
    bit          expect_done = 1'b0;
    logic        prev_tx     = 1'b1;

    // Monitor: capture pre-edge inputs, then judge post-edge outputs.
    always begin : mon
      logic       s_tick;
      logic       s_rst;
      logic       s_push;
      logic [7:0] s_data;
      bit         done_now;
      bit         busy_exp;
      @(negedge clk);
      s_tick = baud_tick;
      s_rst  = rst;
      s_push = tx_valid && tx_ready[g];
      s_data = tx_data;
      @(posedge clk);
      #1;
      if (s_rst) begin
        exp_q.delete();
        in_frame    = 1'b0;
        expect_done = 1'b0;
        prev_tx     = 1'b1;
        check($sformatf("lane%0d reset tx", g), int'(tx_line[g]), 1);
        check($sformatf("lane%0d reset tx_busy", g), int'(tx_busy[g]), 0);
        check($sformatf("lane%0d reset tx_done", g), int'(tx_done[g]), 0);
        check($sformatf("lane%0d reset fifo_count", g), int'(fifo_count[g]), 0);
        check($sformatf("lane%0d reset tx_ready", g), int'(tx_ready[g]), 1);
      end else begin
        done_now = s_tick && expect_done;
        if (done_now || tx_done[g])
          check($sformatf("lane%0d tx_done", g), int'(tx_done[g]), int'(done_now));
        if (s_tick) begin
          expect_done = 1'b0;
          busy_exp    = 1'b1;
          if (in_frame) begin
            got[pos] = tx_line[g];
            pos++;
            if (pos == NB) begin
              check($sformatf("lane%0d frame", g), int'(got), int'(cur_exp));
              in_frame    = 1'b0;
              expect_done = 1'b1;
            end
          end else if (exp_q.size() > 0) begin
            // A queued byte must start on this very tick.
            check($sformatf("lane%0d start bit", g), int'(tx_line[g]), 0);
            cur_exp  = exp_q.pop_front();
            got      = '1;
            got[0]   = tx_line[g];
            pos      = 1;
            in_frame = 1'b1;
          end else begin
            check($sformatf("lane%0d idle line", g), int'(tx_line[g]), 1);
            busy_exp = 1'b0;
          end
          check($sformatf("lane%0d tx_busy", g), int'(tx_busy[g]), int'(busy_exp));
        end else begin
          check($sformatf("lane%0d hold", g), int'(tx_line[g]), int'(prev_tx));
        end
        if (s_push) exp_q.push_back(frame_bits(s_data, PE));
        check($sformatf("lane%0d fifo_count", g), int'(fifo_count[g]), exp_q.size());
        check($sformatf("lane%0d tx_ready", g), int'(tx_ready[g]), int'(exp_q.size() < DEPTH));
        prev_tx = tx_line[g];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Baud tick generator
  // -------------------------------------------------------------------------
  initial begin
    int tick_cnt;
    tick_cnt  = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (tick_mode)
        0: baud_tick = 1'b0;
        1: begin
          baud_tick = (tick_cnt == 15);
          tick_cnt  = (tick_cnt + 1) % 16;
        end
        2: baud_tick = 1'b1;
        default: baud_tick = ($urandom_range(3) == 0);
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Offer one byte once both lanes are ready, so both accept it.
  task automatic push_byte(logic [7:0] d);
    int n = 0;
    while (tx_ready != 2'b11 && n < 2000) begin
      step(1);
      n++;
    end
    check("push ready timeout", int'(n < 2000), 1);
    tx_valid = 1'b1;
    tx_data  = d;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(string name, int bound);
    int n = 0;
    while (!(tx_busy == 2'b00 && fifo_count[0] == 0 && fifo_count[1] == 0) && n < bound) begin
      step(1);
      n++;
    end
    check({name, " drain timeout"}, int'(n < bound), 1);
    step(20);
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    int n;
    int ticks;
    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    step(3);
    rst = 1'b0;
    step(2);

    // Single frames and a back-to-back burst, tick every 16 clks.
    tick_mode = 1;
    push_byte(8'hA5);
    wait_idle("a5", 600);
    push_byte(8'h07);
    wait_idle("07", 600);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_idle("burst", 1200);

    // No ticks: six offers, only DEPTH of them fit.
    tick_mode = 0;
    step(3);
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'($urandom);
      step(1);
    end
    tx_valid = 1'b0;
    check("full tx_ready", int'(tx_ready[0]), 0);
    check("full fifo_count", int'(fifo_count[0]), DEPTH);
    check("full tx idle", int'(tx_line), 3);
    tick_mode = 1;
    wait_idle("full", 2000);

    // Reset in the middle of the data bits of 0xFF.
    push_byte(8'hFF);
    n = 0;
    while (!tx_busy[0] && n < 200) begin
      step(1);
      n++;
    end
    ticks = 0;
    while (ticks < 4 && n < 400) begin
      if (baud_tick) ticks++;
      step(1);
      n++;
    end
    check("reach data bit 3", int'(n < 400), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort tx", int'(tx_line), 3);
    check("abort tx_busy", int'(tx_busy), 0);
    check("abort fifo_count", int'(fifo_count[0]), 0);
    push_byte(8'h3C);
    wait_idle("after reset", 600);

    // Randomised traffic with varying tick patterns and rare resets.
    for (int blk = 0; blk < 8; blk++) begin
      tick_mode = 1 + $urandom_range(2);
      for (int c = 0; c < 250; c++) begin
        tx_valid = ($urandom_range(2) == 0);
        tx_data  = 8'($urandom);
        rst      = ($urandom_range(399) == 0);
        step(1);
      end
    end
    tx_valid = 1'b0;
    rst      = 1'b0;

    tick_mode = 2;
    wait_idle("final", 400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter paired with the existing UART receiver.
- Accepts bytes over a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte as: start bit, 8 data bits LSB first, optional even-parity bit, stop bit.
- Bit timing comes from the shared external baud_tick strobe, one bit per tick. Frames match the receiver's format exactly.

Parameters:
- FIFO_DEPTH, 4: number of buffered bytes; must be a power of 2, ≥2.
- PARITY_EN, 1: 1 = insert even-parity bit (parity = XOR of data bits); 0 = no parity bit.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-clk-wide strobe, one per bit period.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO can accept a byte (= !full).
- tx  output  1  serial line; idles high; registered output.
- tx_busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-clk pulse at end of each frame's stop bit.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Behaviour:

Reset (sync, rst=1 at posedge):
- tx=1, tx_busy=0, tx_done=0, fifo_count=0, tx_ready=1.
- FIFO flushed; state IDLE; bit counter 0.
- Reset mid-frame aborts the frame; tx is 1 from the next cycle.

FIFO:
- Push when tx_valid && tx_ready.
- tx_ready is combinational !full. When full, no push is accepted even if a pop occurs in the same cycle.
- A byte pushed in cycle N can be popped no earlier than cycle N+1.
- Push and pop in the same cycle (not full, not empty): fifo_count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.

FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur only on clk edges where baud_tick=1; between ticks, state, tx and the counters hold.
- IDLE: on tick with FIFO non-empty → pop byte into shift register, compute parity, tx<=0, go to START. On tick with FIFO empty → stay, tx=1.
- START: on tick → tx<=shift[0], bit_cnt<=0, go to DATA.
- DATA: on tick with bit_cnt<7 → shift right, tx<=next bit, bit_cnt+1. On tick with bit_cnt==7:
  - PARITY_EN=1 → tx<=parity, go to PARITY.
  - PARITY_EN=0 → tx<=1, go to STOP.
- PARITY: on tick → tx<=1, go to STOP.
- STOP: on tick → tx_done=1 for that single clk.
  - FIFO non-empty → pop immediately, tx<=0, go to START (back-to-back frames, no extra idle bit).
  - FIFO empty → tx stays 1, go to IDLE.

Frame length and timing:
- Each bit is held for exactly one tick interval.
- Frame = 11 tick intervals (PARITY_EN=1) or 10 (PARITY_EN=0).
- Latency: first tick after a byte becomes available in an idle FIFO drives the start bit, visible one clk after that tick.

Other rules:
- tx_busy = (state != IDLE); high from the start bit through the end of the stop bit.
- baud_tick held high continuously is legal: the FSM advances one bit per clk.

Test Plan:
- PARITY_EN=1, push 0xA5 while idle, tick every 16 clks → tx bit sequence 0,1,0,1,0,0,1,0,1,0(parity),1. tx_done pulses once; tx_busy low afterwards; fifo_count returns to 0.
- Push 0x07 → data bits 1,1,1,0,0,0,0,0, parity 1, stop 1. Loop tx into the UART receiver → d_out_rx=0x07, p_error=0, stop_error=0.
- Push 0x11, 0x22, 0x33 back-to-back → three contiguous 11-bit frames with no idle bit between them. Exactly 3 tx_done pulses; bytes appear in push order.
- With baud_tick held low, assert tx_valid for 6 cycles with FIFO_DEPTH=4 → exactly 4 accepted; tx_ready=0 and fifo_count=4 after the 4th push; tx stays 1.
- Assert rst during the DATA state at bit 3 of 0xFF → next cycle tx=1, tx_busy=0, fifo_count=0. A new push after reset produces a full, correct frame.
- PARITY_EN=0, push 0x80 → tx sequence 0,0,0,0,0,0,0,0,1,1 (10 bits); tx_done asserted at the 10th tick.
